// File: rtl/jtag_readback_pkg.sv
// Shared types and constants for the JTAG readback shifter: FSM states,
// frame field widths and the synchronized-bus bit positions.
package jtag_readback_pkg;

    localparam int         CNT_WIDTH     = 8;
    localparam int         MAGIC_WIDTH   = 4;
    localparam logic [3:0] MAGIC_DEFAULT = 4'hA;

    // Bit positions of the BSCANE2 signals inside the synchronized bus.
    localparam int SYNC_BUS_WIDTH = 4;
    localparam int SYNC_DRCK      = 0;
    localparam int SYNC_CAPTURE   = 1;
    localparam int SYNC_SHIFT     = 2;
    localparam int SYNC_TDI       = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOADED,
        SHIFT
    } state_e;

    function automatic int frame_width(input int data_width);
        return data_width + CNT_WIDTH + MAGIC_WIDTH;
    endfunction

endpackage

// File: rtl/jtag_readback_shifter_if.sv
// DR-side BSCANE2 signals for the readback USER register.
// master = BSCANE2 primitive side, slave = fabric readback shifter.
interface jtag_readback_shifter_if;

    logic jtag_drck_i;
    logic jtag_capture_i;
    logic jtag_shift_i;
    logic jtag_tdi_i;
    logic jtag_tdo_o;

    modport master (
        output jtag_drck_i,
        output jtag_capture_i,
        output jtag_shift_i,
        output jtag_tdi_i,
        input  jtag_tdo_o
    );

    modport slave (
        input  jtag_drck_i,
        input  jtag_capture_i,
        input  jtag_shift_i,
        input  jtag_tdi_i,
        output jtag_tdo_o
    );

endinterface

// File: rtl/jtag_sync_edge.sv
// Multi-stage synchronizer for the BSCANE2 DR bus plus DRCK edge detection.
// Every bit shares the same depth so the bus stays mutually aligned.
module jtag_sync_edge #(
    parameter int SYNC_STAGES = 2,  // minimum 2
    parameter int WIDTH       = 4,
    parameter int DRCK_BIT    = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic                              drck_q, drck_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
        drck_d = sync_q[SYNC_STAGES-1][DRCK_BIT];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            drck_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            drck_q <= drck_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o[DRCK_BIT] & ~drck_q;
    assign fall_o = ~sync_o[DRCK_BIT] & drck_q;

endmodule

// File: rtl/jtag_readback_shifter.sv
// Readback USER-DR shifter: loads {MAGIC, capture count, data_i} on CAPTURE
// and shifts it out LSB-first on TDO, all oversampled in the fabric clock.
module jtag_readback_shifter
    import jtag_readback_pkg::*;
#(
    parameter int         DATA_WIDTH  = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] MAGIC       = MAGIC_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    jtag_readback_shifter_if.slave jtag,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  capture_stb_o,
    output logic                  frame_done_o,
    output logic                  busy_o
);

    localparam int             FRAME_WIDTH = frame_width(DATA_WIDTH);
    localparam int             BIT_CNT_W   = $clog2(FRAME_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = BIT_CNT_W'(FRAME_WIDTH);

    logic [SYNC_BUS_WIDTH-1:0] sync_bus;
    logic                      drck_rise, drck_fall;

    jtag_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .WIDTH      (SYNC_BUS_WIDTH),
        .DRCK_BIT   (SYNC_DRCK)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .async_i({jtag.jtag_tdi_i, jtag.jtag_shift_i, jtag.jtag_capture_i, jtag.jtag_drck_i}),
        .sync_o (sync_bus),
        .rise_o (drck_rise),
        .fall_o (drck_fall)
    );

    logic capture_s, shift_s, tdi_s;
    logic cap_rise, shift_rise;
    logic [FRAME_WIDTH-1:0] frame;

    assign capture_s  = sync_bus[SYNC_CAPTURE];
    assign shift_s    = sync_bus[SYNC_SHIFT];
    assign tdi_s      = sync_bus[SYNC_TDI];
    assign cap_rise   = drck_rise & capture_s;
    assign shift_rise = drck_rise & shift_s & ~capture_s;

    state_e                 state_q, state_d;
    logic [FRAME_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_WIDTH-1:0]   cap_cnt_q, cap_cnt_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   tdo_q, tdo_d;
    logic                   cap_stb_q, cap_stb_d;
    logic                   frame_done_q, frame_done_d;
    logic                   busy_q, busy_d;

    assign frame = {MAGIC, cap_cnt_q, data_i};

    // NOTE: every signal gets a default first so the combinational block cannot infer latches.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cap_cnt_d    = cap_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        tdo_d        = tdo_q;
        cap_stb_d    = 1'b0;
        frame_done_d = 1'b0;

        // Fall and rise never coincide, so TDO launch on fall needs no priority.
        if (drck_fall) begin
            tdo_d = shreg_q[0];
        end

        if (cap_rise) begin
            shreg_d   = frame;
            cap_cnt_d = cap_cnt_q + 1'b1;
            bit_cnt_d = '0;
            tdo_d     = frame[0];
            cap_stb_d = 1'b1;
            state_d   = LOADED;
        end else if (shift_rise) begin
            shreg_d = {tdi_s, shreg_q[FRAME_WIDTH-1:1]};
            if (bit_cnt_q != BIT_CNT_MAX) begin
                bit_cnt_d    = bit_cnt_q + 1'b1;
                frame_done_d = (bit_cnt_q == BIT_CNT_MAX - 1'b1);
            end
            state_d = SHIFT;
        end else if (state_q == SHIFT && !shift_s && !capture_s) begin
            // Only SHIFT can have seen a shift rise; LOADED waits for one.
            state_d = IDLE;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cap_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            tdo_q        <= 1'b0;
            cap_stb_q    <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cap_cnt_q    <= cap_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            tdo_q        <= tdo_d;
            cap_stb_q    <= cap_stb_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign jtag.jtag_tdo_o = tdo_q;
    assign capture_stb_o   = cap_stb_q;
    assign frame_done_o    = frame_done_q;
    assign busy_o          = busy_q;

endmodule

// File: doc/jtag_readback_shifter.md
Name: jtag_readback_shifter

Overview:
- Return path for the LUTRAM-over-JTAG test harness: the command path writes LUTRAM over a USER DR, and this block reads LUTRAM and status back over a second USER DR.
- Oversamples the BSCANE2 DR-side signals in the fabric clock domain.
- On CAPTURE, loads a fixed-format frame: magic, capture count, sampled data.
- On SHIFT, shifts the frame out LSB-first on TDO.

Parameters:
- DATA_WIDTH, 8: width of sampled data_i (e.g. LUTRAM SPO outputs, padded).
- SYNC_STAGES, 2: synchronizer depth for all jtag_* inputs; minimum 2.
- MAGIC, 4'hA: constant placed in the frame's top 4 bits.

Ports:
- clk_i  in  1  fabric clock; sole clock of the block.
- rst_i  in  1  synchronous, active-high reset.
- jtag_drck_i  in  1  BSCANE2 DRCK, treated as data and oversampled.
- jtag_capture_i  in  1  BSCANE2 CAPTURE.
- jtag_shift_i  in  1  BSCANE2 SHIFT.
- jtag_tdi_i  in  1  BSCANE2 TDI.
- data_i  in  DATA_WIDTH  status/readback word, sampled on capture.
- jtag_tdo_o  out  1  to BSCANE2 TDO.
- capture_stb_o  out  1  one-cycle pulse per accepted capture.
- frame_done_o  out  1  one-cycle pulse when the FRAME_WIDTH-th bit has been shifted.
- busy_o  out  1  high in LOADED or SHIFT.

Behaviour:
- Single clock domain (clk_i); reset is synchronous and active-high on rst_i.
- FRAME_WIDTH = DATA_WIDTH+12. Frame layout:
  - [DATA_WIDTH-1:0] = data_i
  - [DATA_WIDTH+7:DATA_WIDTH] = cap_cnt (8-bit)
  - [FRAME_WIDTH-1:FRAME_WIDTH-4] = MAGIC
- Input synchronization:
  - drck, capture, shift and tdi each pass through SYNC_STAGES flops, so all four stay mutually aligned.
  - drck_q holds the previous synced DRCK.
  - rise = synced DRCK & ~drck_q; fall = ~synced DRCK & drck_q.
- Timing requirement: DRCK high and low phases must each be ≥ SYNC_STAGES+1 clk_i periods. This is not checked in RTL.
- On rise with synced capture = 1 (capture has priority over shift):
  - shreg <= frame, with data_i taken in this same cycle.
  - cap_cnt then increments, wrapping 255->0; the frame carries the pre-increment value.
  - bit_cnt <= 0; capture_stb_o = 1 next cycle; state -> LOADED.
- On rise with synced shift = 1 and capture = 0:
  - shreg <= {synced tdi, shreg[FRAME_WIDTH-1:1]}.
  - bit_cnt increments, saturating at FRAME_WIDTH.
  - When bit_cnt reaches FRAME_WIDTH, frame_done_o pulses once.
  - State -> SHIFT.
- After FRAME_WIDTH shifts, TDO carries TDI delayed by FRAME_WIDTH bits (loopback).
- TDO update:
  - On fall, jtag_tdo_o <= shreg[0], so TDO changes on the DRCK falling edge, matching the JTAG convention.
  - On the rise after capture, jtag_tdo_o <= frame[0] immediately, so bit 0 is valid before the first shift edge.
- State machine (shared enum):
  - IDLE -> LOADED on capture rise.
  - LOADED -> SHIFT on shift rise.
  - LOADED or SHIFT -> IDLE when synced shift = 0 and synced capture = 0 for a whole cycle after at least one shift rise. In LOADED the state is held until a shift rise occurs.
  - Capture rise in any state reloads and goes to LOADED.
- Shift rise in IDLE: shifts normally and goes to SHIFT. The frame contents are stale, and bit_cnt continues from its last value.
- Reset values:
  - shreg = 0, cap_cnt = 0, bit_cnt = 0, jtag_tdo_o = 0, all pulses 0, state = IDLE.
  - Synchronizer flops reset to 0. A DRCK already high at reset release therefore generates a rise after SYNC_STAGES cycles; that is accepted behaviour.
- Reset mid-shift: the frame is discarded; the next frame carries cap_cnt = 0.

Decomposition:
- Package jtag_readback_pkg:
  - state enum {IDLE, LOADED, SHIFT}
  - MAGIC default
  - CNT_WIDTH = 8
  - FRAME_WIDTH function of DATA_WIDTH
- One sub-module, jtag_sync_edge: SYNC_STAGES synchronizer for a bus of 4 bits plus DRCK rise/fall detection. Instantiated once.

Test Plan:
- Reset, then capture with data_i = 8'h5A and DATA_WIDTH = 8, then 20 shift clocks with TDI = 0 -> TDO bit sequence LSB-first = 20'hA005A; capture_stb_o one pulse; frame_done_o pulses after the 20th rise.
- Two consecutive captures with data_i = 8'h03, then 8'hFF -> cap_cnt fields 0x00, then 0x01; both MAGIC = 4'hA.
- 300 captures -> the 257th frame shows cap_cnt = 0x00 (wrap), with no glitch on busy_o.
- Capture, 20 shifts, then 8 shifts with TDI = 8'b1011_0010 -> TDO bits 21-28 = 0; TDI pattern reappears at bits 41-48 (FRAME_WIDTH delay).
- CAPTURE and SHIFT both high on one DRCK rise -> treated as capture: shreg reloads, bit_cnt = 0, no shift.
- rst_i pulsed after 7 of 20 shifts -> jtag_tdo_o = 0, state IDLE; the next capture frame has cap_cnt = 0x00.
